usb_extbus_master: RTL and testbench
====================================

USB_EXTBUS_MASTER -- requirements
Module: usb_extbus_master

Interface
REQ-001 Parameters: ALE_CYC, default 2, ALEn low-pulse length in clocks; SETUP_CYC, default 2, clocks from CEn low to first strobe; STROBE_CYC, default 3, RDn/WRn low time; HOLD_CYC, default 2, clocks between strobes and after the last strobe.
REQ-002 Ports SHALL be as follows:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  8  register address.
- cmd_len  in  8  burst length minus 1 (0 means 1 byte).
- wdata  in  8  write byte.
- wdata_valid  in  1  write byte available.
- wdata_ready  out  1  write byte consumed when wdata_valid && wdata_ready.
- rdata  out  8  read byte.
- rdata_valid  out  1  one-clock pulse per read byte; no backpressure.
- busy  out  1  transaction in progress.
- usb_addr  out  8  address bus.
- usb_alen, usb_cen, usb_rdn, usb_wrn  out  1 each  active-low bus strobes.
- usb_d_out  out  8  data-bus drive value.
- usb_d_oe  out  1  data-bus output enable.
- usb_d_in  in  8  data-bus sample.

Function
REQ-003 The FSM states SHALL be IDLE, ALE, SETUP, WAITD, STROBE and HOLD.
REQ-004 In IDLE, cmd_ready SHALL be 1; on handshake, latch cmd_write, cmd_addr and cmd_len into the remaining-byte counter, and go to ALE.
REQ-005 ALE: usb_alen=0 and usb_addr=latched address for exactly ALE_CYC clocks, then go to SETUP.
REQ-006 SETUP: usb_cen=0 for SETUP_CYC clocks; then go to WAITD if writing, STROBE if reading.
REQ-007 usb_cen SHALL stay 0 from SETUP entry until the clock HOLD exits after the final byte; usb_addr SHALL stay stable throughout the burst.
REQ-008 WAITD: wdata_ready=1; on the wdata handshake, register wdata into usb_d_out and go to STROBE.
- usb_d_oe SHALL be 1 from WAITD exit until the end of that byte's HOLD.
- wdata_ready SHALL be 0 in every other state.
REQ-009 STROBE: usb_wrn=0 (write) or usb_rdn=0 (read) for exactly STROBE_CYC clocks; the other strobe stays 1.
REQ-010 Read sampling: usb_d_in SHALL be registered on the last STROBE clock; rdata is updated and rdata_valid=1 on the following clock.
REQ-011 HOLD: strobes high for HOLD_CYC clocks.
- If the remaining-byte counter is 0, go to IDLE.
- Otherwise decrement it and go to WAITD (write) or STROBE (read).
- ALE is not repeated within a burst.
REQ-012 A burst SHALL perform exactly cmd_len+1 strobes; cmd_len=255 yields 256 strobes with no counter wrap.
REQ-013 Write stall: absence of wdata_valid in WAITD SHALL hold the FSM indefinitely with CEn low and no strobe.
REQ-014 busy SHALL be 1 in all states except IDLE; cmd_ready=~busy.
REQ-015 usb_d_oe SHALL never be 1 during a read burst or while usb_rdn=0.
REQ-016 All bus outputs SHALL be driven directly from flops (glitch-free).
REQ-017 Phase-length counters SHALL be 8 bits; parameter values 1..255 are legal, and 0 SHALL be treated as 1.

Reset
REQ-018 Assertion of reset_n=0 at any time, including mid-burst, SHALL immediately force the following:
- FSM=IDLE.
- usb_alen, usb_cen, usb_rdn, usb_wrn = 1.
- usb_d_oe=0, usb_d_out=0, usb_addr=0.
- rdata=0, rdata_valid=0, wdata_ready=0.
- busy=0, cmd_ready=0 while in reset.
- All counters cleared.
REQ-019 After reset deassertion, cmd_ready SHALL become 1 on the first clock edge.

Structure
REQ-020 The state encoding and default timing constants SHALL live in the shared package cw_extbus_pkg, for reuse by the bench model of the FPGA responder side.
REQ-021 One sub-module, extbus_phase_timer (a loadable down-counter with a done flag), SHALL be used for all ALE, SETUP, STROBE and HOLD phase timing.
REQ-022 The target RTL size is 150-300 lines.

Verification
REQ-023 Single write (defaults): addr=0x2A, len=0, wdata=0x5C offered immediately ->
- ALEn low for 2 clocks with usb_addr=0x2A;
- CEn low, then WRn low for 3 clocks with usb_d_out=0x5C and oe=1;
- IDLE 2 clocks after WRn rises.
REQ-024 Read burst: addr=0x04, len=3, responder returns 0x11, 0x22, 0x33, 0x44 ->
- exactly 4 RDn pulses and one ALEn pulse;
- 4 rdata_valid pulses carrying those values in order;
- oe=0 throughout.
REQ-025 Write stall: len=1, second wdata_valid withheld 20 clocks ->
- CEn stays low and WRn stays high for those clocks;
- the second strobe begins the clock after the WAITD handshake.
REQ-026 Mid-burst reset: reset_n pulled low during the second STROBE of a len=5 write ->
- all strobes high, oe=0 and busy=0 in the same clock, without waiting for an edge;
- cmd_ready=1 one clock after release.
REQ-027 Max length / parameters: len=255 read with ALE_CYC=1, STROBE_CYC=1, HOLD_CYC=1 ->
- exactly 256 RDn pulses;
- each RDn pulse lasts 1 clock, with 1 clock high between pulses.
REQ-028 Back-to-back commands: cmd_valid held high across two commands ->
- the second is accepted only in IDLE after the first completes;
- there is a fresh ALEn pulse per command.

Source files
------------

// File: rtl/cw_extbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cw_extbus_pkg
//  Description : Shared state encoding and default phase timing for the
//                external-bus master and its responder-side bench model.
//  Revision    : 1.0 - initial release
// ============================================================================
package cw_extbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALE    = 3'd1,
        ST_SETUP  = 3'd2,
        ST_WAITD  = 3'd3,
        ST_STROBE = 3'd4,
        ST_HOLD   = 3'd5
    } extbus_state_t;

    localparam int unsigned c_ALE_CYC_DEFAULT    = 2;
    localparam int unsigned c_SETUP_CYC_DEFAULT  = 2;
    localparam int unsigned c_STROBE_CYC_DEFAULT = 3;
    localparam int unsigned c_HOLD_CYC_DEFAULT   = 2;
    localparam int unsigned c_PHASE_W            = 8;

endpackage
`default_nettype wire

// File: rtl/extbus_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : extbus_phase_timer
//  Description : Loadable 8-bit down-counter; o_done is high on the last
//                clock of a phase of i_load_len clocks (0 behaves as 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module extbus_phase_timer
    import cw_extbus_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_load,
    input  logic [c_PHASE_W-1:0] i_load_len,
    output logic                 o_done
);

    logic [c_PHASE_W-1:0] r_count;

    // Loading N-1 makes the phase last exactly N clocks including the load cycle's successor
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (i_load_len == '0) ? '0 : i_load_len - 1'b1;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/usb_extbus_master.sv
`default_nettype none
// ============================================================================
//  Module      : usb_extbus_master
//  Description : Multiplexed-address external bus master issuing read/write
//                bursts with ALE, CEn, RDn/WRn strobes and programmable timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_extbus_master
    import cw_extbus_pkg::*;
#(
    parameter int unsigned ALE_CYC    = c_ALE_CYC_DEFAULT,
    parameter int unsigned SETUP_CYC  = c_SETUP_CYC_DEFAULT,
    parameter int unsigned STROBE_CYC = c_STROBE_CYC_DEFAULT,
    parameter int unsigned HOLD_CYC   = c_HOLD_CYC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_len,
    input  logic [7:0] wdata,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       busy,
    output logic [7:0] usb_addr,
    output logic       usb_alen,
    output logic       usb_cen,
    output logic       usb_rdn,
    output logic       usb_wrn,
    output logic [7:0] usb_d_out,
    output logic       usb_d_oe,
    input  logic [7:0] usb_d_in
);

    localparam logic [c_PHASE_W-1:0] c_ALE_LEN    = c_PHASE_W'(ALE_CYC);
    localparam logic [c_PHASE_W-1:0] c_SETUP_LEN  = c_PHASE_W'(SETUP_CYC);
    localparam logic [c_PHASE_W-1:0] c_STROBE_LEN = c_PHASE_W'(STROBE_CYC);
    localparam logic [c_PHASE_W-1:0] c_HOLD_LEN   = c_PHASE_W'(HOLD_CYC);

    extbus_state_t r_state, w_state_nxt;

    logic       r_write,       w_write_nxt;
    logic [7:0] r_addr,        w_addr_nxt;
    logic [7:0] r_remaining,   w_rem_nxt;
    logic       r_alen,        w_alen_nxt;
    logic       r_cen,         w_cen_nxt;
    logic       r_rdn,         w_rdn_nxt;
    logic       r_wrn,         w_wrn_nxt;
    logic       r_d_oe,        w_d_oe_nxt;
    logic [7:0] r_d_out,       w_d_out_nxt;
    logic [7:0] r_rdata,       w_rdata_nxt;
    logic       r_rdata_valid, w_rdata_valid_nxt;
    logic       r_cmd_ready,   w_cmd_ready_nxt;

    logic                 w_tmr_load;
    logic [c_PHASE_W-1:0] w_tmr_len;
    logic                 w_tmr_done;

    extbus_phase_timer u_phase_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_len (w_tmr_len),
        .o_done     (w_tmr_done)
    );

    // Bus outputs are registered copies of the next-state values so they never glitch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_alen        <= 1'b1;
            r_cen         <= 1'b1;
            r_rdn         <= 1'b1;
            r_wrn         <= 1'b1;
            r_d_oe        <= 1'b0;
            r_d_out       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_cmd_ready   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_write       <= w_write_nxt;
            r_addr        <= w_addr_nxt;
            r_remaining   <= w_rem_nxt;
            r_alen        <= w_alen_nxt;
            r_cen         <= w_cen_nxt;
            r_rdn         <= w_rdn_nxt;
            r_wrn         <= w_wrn_nxt;
            r_d_oe        <= w_d_oe_nxt;
            r_d_out       <= w_d_out_nxt;
            r_rdata       <= w_rdata_nxt;
            r_rdata_valid <= w_rdata_valid_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_write_nxt       = r_write;
        w_addr_nxt        = r_addr;
        w_rem_nxt         = r_remaining;
        w_alen_nxt        = r_alen;
        w_cen_nxt         = r_cen;
        w_rdn_nxt         = r_rdn;
        w_wrn_nxt         = r_wrn;
        w_d_oe_nxt        = r_d_oe;
        w_d_out_nxt       = r_d_out;
        w_rdata_nxt       = r_rdata;
        w_rdata_valid_nxt = 1'b0;
        w_tmr_load        = 1'b0;
        w_tmr_len         = c_ALE_LEN;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_write_nxt = cmd_write;
                    w_addr_nxt  = cmd_addr;
                    w_rem_nxt   = cmd_len;
                    w_alen_nxt  = 1'b0;
                    w_tmr_load  = 1'b1;
                    w_tmr_len   = c_ALE_LEN;
                    w_state_nxt = ST_ALE;
                end
            end
            ST_ALE: begin
                if (w_tmr_done) begin
                    w_alen_nxt  = 1'b1;
                    w_cen_nxt   = 1'b0;
                    w_tmr_load  = 1'b1;
                    w_tmr_len   = c_SETUP_LEN;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tmr_done) begin
                    if (r_write) begin
                        w_state_nxt = ST_WAITD;
                    end else begin
                        w_rdn_nxt   = 1'b0;
                        w_tmr_load  = 1'b1;
                        w_tmr_len   = c_STROBE_LEN;
                        w_state_nxt = ST_STROBE;
                    end
                end
            end
            ST_WAITD: begin
                if (wdata_valid) begin
                    w_d_out_nxt = wdata;
                    w_d_oe_nxt  = 1'b1;
                    w_wrn_nxt   = 1'b0;
                    w_tmr_load  = 1'b1;
                    w_tmr_len   = c_STROBE_LEN;
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (w_tmr_done) begin
                    w_rdn_nxt   = 1'b1;
                    w_wrn_nxt   = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_len   = c_HOLD_LEN;
                    w_state_nxt = ST_HOLD;
                    if (!r_write) begin
                        w_rdata_nxt       = usb_d_in;
                        w_rdata_valid_nxt = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tmr_done) begin
                    w_d_oe_nxt = 1'b0;
                    if (r_remaining == '0) begin
                        w_cen_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_rem_nxt = r_remaining - 1'b1;
                        // Address phase is not repeated inside a burst
                        if (r_write) begin
                            w_state_nxt = ST_WAITD;
                        end else begin
                            w_rdn_nxt   = 1'b0;
                            w_tmr_load  = 1'b1;
                            w_tmr_len   = c_STROBE_LEN;
                            w_state_nxt = ST_STROBE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = (r_state != ST_IDLE);
    assign wdata_ready = (r_state == ST_WAITD);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign usb_addr    = r_addr;
    assign usb_alen    = r_alen;
    assign usb_cen     = r_cen;
    assign usb_rdn     = r_rdn;
    assign usb_wrn     = r_wrn;
    assign usb_d_out   = r_d_out;
    assign usb_d_oe    = r_d_oe;

endmodule
`default_nettype wire

// File: tb/tb_usb_extbus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_extbus_master
//  Description : Self-checking bench: bus monitor plus responder model for a
//                default-timing master and a fast-timing master.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_extbus_master;

    localparam int E_ALE = 2;
    localparam int E_STB = 3;
    localparam int E_HOLD = 2;

    logic clk, reset_n;
    logic cmd_valid, cmd_write, wdata_valid;
    logic [7:0] cmd_addr, cmd_len, wdata;
    logic cmd_ready, wdata_ready, rdata_valid, busy;
    logic usb_alen, usb_cen, usb_rdn, usb_wrn, usb_d_oe;
    logic [7:0] rdata, usb_addr, usb_d_out, usb_d_in;

    logic cmd_valid_b, cmd_write_b, wdata_valid_b;
    logic [7:0] cmd_addr_b, cmd_len_b, wdata_b;
    logic cmd_ready_b, wdata_ready_b, rdata_valid_b, busy_b;
    logic usb_alen_b, usb_cen_b, usb_rdn_b, usb_wrn_b, usb_d_oe_b;
    logic [7:0] rdata_b, usb_addr_b, usb_d_out_b, usb_d_in_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] resp_mem [0:255];
    int rd_idx = 0;
    int rd_idx_b = 0;

    assign usb_d_in   = usb_rdn ? 8'h00 : resp_mem[rd_idx[7:0]];
    assign usb_d_in_b = usb_rdn_b ? 8'h00 : (rd_idx_b[7:0] ^ 8'hA5);

    usb_extbus_master dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .usb_addr(usb_addr),
        .usb_alen(usb_alen), .usb_cen(usb_cen), .usb_rdn(usb_rdn), .usb_wrn(usb_wrn),
        .usb_d_out(usb_d_out), .usb_d_oe(usb_d_oe), .usb_d_in(usb_d_in)
    );

    usb_extbus_master #(.ALE_CYC(1), .SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(1)) dut_fast (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_write(cmd_write_b), .cmd_addr(cmd_addr_b), .cmd_len(cmd_len_b),
        .wdata(wdata_b), .wdata_valid(wdata_valid_b), .wdata_ready(wdata_ready_b),
        .rdata(rdata_b), .rdata_valid(rdata_valid_b), .busy(busy_b), .usb_addr(usb_addr_b),
        .usb_alen(usb_alen_b), .usb_cen(usb_cen_b), .usb_rdn(usb_rdn_b), .usb_wrn(usb_wrn_b),
        .usb_d_out(usb_d_out_b), .usb_d_oe(usb_d_oe_b), .usb_d_in(usb_d_in_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Bus monitor for the default-timing master: records pulses and protocol breaches
    int cyc = 0, alen_run = 0, stb_run = 0, last_rise = 0, viol = 0, hs_cnt = 0;
    int ale_w_q[$], stb_w_q[$], gap_q[$];
    logic [7:0] ale_addr_q[$], wr_data_q[$], rd_data_q[$];
    logic p_alen = 1'b1, p_wrn = 1'b1, p_rdn = 1'b1, p_busy = 1'b0, p_cen = 1'b1, cur_write = 1'b0;
    logic [7:0] p_addr = 8'h00, p_dout = 8'h00;

    initial forever begin
        @(negedge clk);
        #1;
        cyc++;
        if (!usb_alen) begin
            if (p_alen) ale_addr_q.push_back(usb_addr);
            alen_run++;
        end else if (alen_run > 0) begin
            ale_w_q.push_back(alen_run);
            alen_run = 0;
        end
        if (!usb_wrn && p_wrn) wr_data_q.push_back(usb_d_out);
        if (!usb_wrn || !usb_rdn) stb_run++;
        else if (stb_run > 0) begin
            stb_w_q.push_back(stb_run);
            stb_run = 0;
            last_rise = cyc;
        end
        if (usb_rdn && !p_rdn) rd_idx++;
        if (p_busy && !busy) gap_q.push_back(cyc - last_rise);
        if (rdata_valid) rd_data_q.push_back(rdata);
        if (cmd_valid && cmd_ready) begin
            hs_cnt++;
            cur_write = cmd_write;
        end
        if (!usb_rdn && usb_d_oe) viol++;
        if (usb_d_oe && !cur_write) viol++;
        if (!usb_wrn && !usb_d_oe) viol++;
        if ((!usb_wrn || !usb_rdn) && usb_cen) viol++;
        if (!usb_wrn && !usb_rdn) viol++;
        if (!usb_cen && !p_cen && usb_addr != p_addr) viol++;
        if (!usb_wrn && !p_wrn && usb_d_out != p_dout) viol++;
        if (cmd_ready && busy) viol++;
        if (wdata_ready && (!cur_write || usb_cen)) viol++;
        p_alen = usb_alen; p_wrn = usb_wrn; p_rdn = usb_rdn; p_busy = busy;
        p_cen = usb_cen; p_addr = usb_addr; p_dout = usb_d_out;
    end

    // Monitor for the fast master: pulse widths, inter-pulse gaps and read data
    int b_pulses = 0, b_wmin = 999, b_wmax = 0, b_gmin = 999, b_gmax = 0, b_run = 0, b_hi = 0;
    int b_rd_cnt = 0, b_rd_ok = 0, b_ale = 0, b_ale_w = 0;
    logic pb_rdn = 1'b1, pb_alen = 1'b1, b_seen = 1'b0;

    initial forever begin
        @(negedge clk);
        #1;
        if (!usb_alen_b) begin
            if (pb_alen) b_ale++;
            b_ale_w++;
        end
        if (!usb_rdn_b) begin
            if (pb_rdn && b_seen) begin
                if (b_hi < b_gmin) b_gmin = b_hi;
                if (b_hi > b_gmax) b_gmax = b_hi;
            end
            b_run++;
        end else begin
            if (!pb_rdn) begin
                b_pulses++;
                if (b_run < b_wmin) b_wmin = b_run;
                if (b_run > b_wmax) b_wmax = b_run;
                b_run = 0;
                b_seen = 1'b1;
                b_hi = 0;
                rd_idx_b++;
            end
            b_hi++;
        end
        if (!busy_b) b_seen = 1'b0;
        if (rdata_valid_b) begin
            if (rdata_b == (b_rd_cnt[7:0] ^ 8'hA5)) b_rd_ok++;
            b_rd_cnt++;
        end
        pb_rdn = usb_rdn_b;
        pb_alen = usb_alen_b;
    end

    task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] l);
        int t;
        t = 0;
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
        chk("cmd_hs_timeout", 32'(t >= 2000), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d, input int stall);
        int t;
        t = 0;
        wdata_valid = 1'b0;
        repeat (stall) @(negedge clk);
        wdata = d; wdata_valid = 1'b1;
        while (!wdata_ready && t < 500) begin @(negedge clk); t++; end
        chk("wdata_hs_timeout", 32'(t >= 500), 0);
        @(negedge clk);
        wdata_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int t;
        t = 0;
        while (busy && t < lim) begin @(negedge clk); t++; end
        chk("idle_timeout", 32'(t >= lim), 0);
        @(negedge clk);
    endtask

    task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] l,
                           input logic fixed, input logic [7:0] d0, input int max_stall);
        logic [7:0] exp_q[$];
        int s_ale, s_aa, s_stb, s_wr, s_rd, s_gap, s_viol, ok, bad, n;
        n = int'(l) + 1;
        s_ale = ale_w_q.size(); s_aa = ale_addr_q.size(); s_stb = stb_w_q.size();
        s_wr = wr_data_q.size(); s_rd = rd_data_q.size(); s_gap = gap_q.size(); s_viol = viol;
        for (int i = 0; i < n; i++) begin
            logic [7:0] v;
            v = fixed ? d0 + 8'(8'h11 * i) : 8'($urandom);
            exp_q.push_back(v);
            if (!wr) resp_mem[8'(rd_idx + i)] = v;
        end
        issue(wr, a, l);
        if (wr) for (int i = 0; i < n; i++) feed(exp_q[i], $urandom_range(max_stall, 0));
        wait_idle(3000);
        chk("ale_count", ale_w_q.size() - s_ale, 1);
        if (ale_w_q.size() > s_ale) chk("ale_width", ale_w_q[s_ale], E_ALE);
        if (ale_addr_q.size() > s_aa) chk("ale_addr", {24'h0, ale_addr_q[s_aa]}, {24'h0, a});
        chk("strobe_count", stb_w_q.size() - s_stb, n);
        bad = 0;
        for (int i = s_stb; i < stb_w_q.size(); i++) if (stb_w_q[i] != E_STB) bad++;
        chk("strobe_width_bad", bad, 0);
        ok = 0;
        if (wr) begin
            for (int i = 0; i < n; i++)
                if (s_wr + i < wr_data_q.size() && wr_data_q[s_wr + i] == exp_q[i]) ok++;
            chk("wr_bytes_ok", ok, n);
            chk("rd_pulses_in_write", rd_data_q.size() - s_rd, 0);
        end else begin
            for (int i = 0; i < n; i++)
                if (s_rd + i < rd_data_q.size() && rd_data_q[s_rd + i] == exp_q[i]) ok++;
            chk("rd_bytes_ok", ok, n);
            chk("rd_valid_count", rd_data_q.size() - s_rd, n);
            chk("wr_strobes_in_read", wr_data_q.size() - s_wr, 0);
        end
        chk("hold_to_idle", (gap_q.size() > s_gap) ? gap_q[gap_q.size() - 1] : -1, E_HOLD);
        chk("protocol_viol", viol - s_viol, 0);
    endtask

    initial begin
        int t, good, s_stb, s_wr, s_ale, s_hs, s_rd, s_viol, ok;
        reset_n = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; wdata = 0; wdata_valid = 0;
        cmd_valid_b = 0; cmd_write_b = 0; cmd_addr_b = 0; cmd_len_b = 0; wdata_b = 0; wdata_valid_b = 0;
        for (int i = 0; i < 256; i++) resp_mem[i] = 8'h00;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {usb_alen, usb_cen, usb_rdn, usb_wrn}, 4'hF);
        chk("rst_oe", usb_d_oe, 0);
        chk("rst_addr", usb_addr, 0);
        chk("rst_dout", usb_d_out, 0);
        chk("rst_rdata", {rdata_valid, rdata}, 0);
        chk("rst_wready", wdata_ready, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", cmd_ready, 1);
        @(negedge clk);

        // Single write and four-byte read with fixed data
        run_txn(1'b1, 8'h2A, 8'd0, 1'b1, 8'h5C, 0);
        run_txn(1'b0, 8'h04, 8'd3, 1'b1, 8'h11, 0);

        // Write stall in WAITD
        s_stb = stb_w_q.size(); s_wr = wr_data_q.size();
        issue(1'b1, 8'h40, 8'd1);
        feed(8'hA1, 0);
        t = 0;
        while (!wdata_ready && t < 500) begin @(negedge clk); t++; end
        chk("stall_wready_timeout", 32'(t >= 500), 0);
        good = 0;
        for (int k = 0; k < 20; k++) begin
            if (!usb_cen && usb_wrn && busy) good++;
            @(negedge clk);
        end
        chk("stall_hold", good, 20);
        wdata = 8'hB2; wdata_valid = 1'b1;
        @(negedge clk);
        wdata_valid = 1'b0;
        chk("strobe_after_hs", usb_wrn, 0);
        wait_idle(500);
        chk("stall_strobes", stb_w_q.size() - s_stb, 2);
        chk("stall_bytes", (wr_data_q.size() == s_wr + 2) ? {wr_data_q[s_wr], wr_data_q[s_wr + 1]} : 16'h0, 16'hA1B2);

        // Reset during the second strobe of a six-byte write
        s_stb = stb_w_q.size();
        wdata = 8'h77; wdata_valid = 1'b1;
        issue(1'b1, 8'h10, 8'd5);
        t = 0;
        while (!(stb_w_q.size() == s_stb + 1 && !usb_wrn) && t < 500) begin @(negedge clk); t++; end
        chk("second_strobe_timeout", 32'(t >= 500), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {usb_alen, usb_cen, usb_rdn, usb_wrn}, 4'hF);
        chk("mid_rst_oe", usb_d_oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_addr_dout", {usb_addr, usb_d_out}, 0);
        chk("mid_rst_wready", wdata_ready, 0);
        wdata_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready_after", cmd_ready, 1);
        @(negedge clk);

        // Back-to-back reads with cmd_valid held high
        s_ale = ale_addr_q.size(); s_hs = hs_cnt; s_rd = rd_data_q.size(); s_viol = viol;
        for (int i = 0; i < 3; i++) resp_mem[8'(rd_idx + i)] = 8'hC0 + 8'(i);
        cmd_write = 1'b0; cmd_addr = 8'h31; cmd_len = 8'd1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_addr = 8'h32; cmd_len = 8'd0;
        t = 0;
        while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
        chk("b2b_second_timeout", 32'(t >= 500), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle(500);
        chk("b2b_handshakes", hs_cnt - s_hs, 2);
        chk("b2b_ale_count", ale_addr_q.size() - s_ale, 2);
        chk("b2b_ale_addrs", (ale_addr_q.size() >= s_ale + 2) ? {ale_addr_q[s_ale], ale_addr_q[s_ale + 1]} : 16'h0, 16'h3132);
        ok = 0;
        for (int i = 0; i < 3; i++)
            if (s_rd + i < rd_data_q.size() && rd_data_q[s_rd + i] == 8'hC0 + 8'(i)) ok++;
        chk("b2b_rd_bytes", ok, 3);
        chk("b2b_viol", viol - s_viol, 0);

        // Randomized bursts
        for (int k = 0; k < 8; k++)
            run_txn(1'($urandom_range(1, 0)), 8'($urandom), 8'($urandom_range(7, 0)), 1'b0, 8'h00, 3);

        // 256-byte read on the fast-timing master
        cmd_write_b = 1'b0; cmd_addr_b = 8'hE7; cmd_len_b = 8'd255; cmd_valid_b = 1'b1;
        t = 0;
        while (!cmd_ready_b && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        cmd_valid_b = 1'b0;
        t = 0;
        while (busy_b && t < 3000) begin @(negedge clk); t++; end
        chk("fast_idle_timeout", 32'(t >= 3000), 0);
        @(negedge clk);
        chk("fast_rd_pulses", b_pulses, 256);
        chk("fast_width_min", b_wmin, 1);
        chk("fast_width_max", b_wmax, 1);
        chk("fast_gap_min", b_gmin, 1);
        chk("fast_gap_max", b_gmax, 1);
        chk("fast_ale", {b_ale[15:0], b_ale_w[15:0]}, 32'h0001_0001);
        chk("fast_rdata_ok", b_rd_ok, 256);
        chk("fast_rdata_count", b_rd_cnt, 256);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
